// File: rtl/seg7_display_mux.sv
// seg7_display_mux: latches a 3-digit BCD BPM value on an update strobe and
// time-multiplexes it onto a 4-digit common-anode seven-segment display.
// Features: leading-zero suppression, per-slot ghost blanking window, dash for
// non-BCD codes, registered active-low outputs with one cycle of latency.
// Optional macro HEARTBEAT_DP_EN: a heartbeat pulse lights the spare digit's
// decimal point for DP_HOLD cycles (stretched, re-triggerable).
module seg7_display_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000,
  parameter int DP_HOLD     = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic       beat,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } slot_t;

  // Hex code to active-low {g,f,e,d,c,b,a}; anything outside 0-9 shows a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
    return pat;
  endfunction

  logic [3:0]       h_r, t_r, o_r;
  logic [CNT_W-1:0] cnt_r;
  slot_t            sel_r, sel_nxt_s;
  logic             wrap_s;
  logic             stretch_on_s;
  logic [3:0]       an_s, an_r;
  logic [6:0]       seg_s, seg_r;
  logic             dp_s, dp_r;

  assign wrap_s = (cnt_r == CNT_MAX);

  // Shadow registers: capture the BCD digits only on the update strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_r <= 4'd0;
      t_r <= 4'd0;
      o_r <= 4'd0;
    end else if (upd) begin
      h_r <= d2;
      t_r <= d1;
      o_r <= d0;
    end else begin
      h_r <= h_r;
      t_r <= t_r;
      o_r <= o_r;
    end
  end

  // Slot timer: counts cycles within a digit slot and wraps at the slot length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (wrap_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Slot FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_r <= DIG0;
    end else begin
      sel_r <= sel_nxt_s;
    end
  end

  // Slot FSM next state: rotate ones -> tens -> hundreds -> spare on each wrap.
  always_comb begin
    sel_nxt_s = sel_r;
    if (wrap_s) begin
      case (sel_r)
        DIG0:    sel_nxt_s = DIG1;
        DIG1:    sel_nxt_s = DIG2;
        DIG2:    sel_nxt_s = DIG3;
        DIG3:    sel_nxt_s = DIG0;
        default: sel_nxt_s = DIG0;
      endcase
    end else begin
      sel_nxt_s = sel_r;
    end
  end

`ifdef HEARTBEAT_DP_EN
  localparam int STR_W = $clog2(DP_HOLD + 1);
  logic [STR_W-1:0] stretch_r;

  // Heartbeat stretch: reload on every beat, otherwise count down to zero and hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stretch_r <= '0;
    end else if (beat) begin
      stretch_r <= STR_W'(DP_HOLD);
    end else if (stretch_r != '0) begin
      stretch_r <= stretch_r - STR_W'(1);
    end else begin
      stretch_r <= stretch_r;
    end
  end

  assign stretch_on_s = (stretch_r != '0);
`else
  logic unused_beat_s;
  assign unused_beat_s = beat;
  assign stretch_on_s  = 1'b0;
`endif

  // Next output pattern: blank window first, then the slot's digit unless suppressed.
  always_comb begin
    an_s  = 4'b1111;
    seg_s = 7'b1111111;
    dp_s  = 1'b1;
    if (cnt_r >= CNT_BLANK) begin
      case (sel_r)
        DIG0: begin
          an_s  = 4'b1110;
          seg_s = seg_decode(o_r);
        end
        DIG1: begin
          if ((h_r != 4'd0) || (t_r != 4'd0)) begin
            an_s  = 4'b1101;
            seg_s = seg_decode(t_r);
          end else begin
            an_s  = 4'b1111;
            seg_s = 7'b1111111;
          end
        end
        DIG2: begin
          if (h_r != 4'd0) begin
            an_s  = 4'b1011;
            seg_s = seg_decode(h_r);
          end else begin
            an_s  = 4'b1111;
            seg_s = 7'b1111111;
          end
        end
        DIG3: begin
          if (stretch_on_s) begin
            an_s = 4'b0111;
            dp_s = 1'b0;
          end else begin
            an_s = 4'b1111;
            dp_s = 1'b1;
          end
        end
        default: begin
          an_s  = 4'b1111;
          seg_s = 7'b1111111;
          dp_s  = 1'b1;
        end
      endcase
    end else begin
      an_s  = 4'b1111;
      seg_s = 7'b1111111;
      dp_s  = 1'b1;
    end
  end

  // Output registers: glitch-free pin drive, all segments/anodes off in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_r  <= 4'b1111;
      seg_r <= 7'b1111111;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_s;
      seg_r <= seg_s;
      dp_r  <= dp_s;
    end
  end

  assign an  = an_r;
  assign seg = seg_r;
  assign dp  = dp_r;

endmodule

// File: tb/tb_seg7_display_mux.sv
// Self-checking bench for seg7_display_mux (REFRESH_DIV=8, BLANK_CYC=2, DP_HOLD=20).
// A frame-position model (edges since reset -> slot/offset) predicts every output.
module tb_seg7_display_mux;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int DH = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       upd = 1'b0;
  logic [3:0] d2 = 4'd0, d1 = 4'd0, d0 = 4'd0;
  logic       beat = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  // Model state
  int         k_m;
  logic [3:0] m_h, m_t, m_o;
  int         lb;
  bit         have_beat;
  logic [6:0] lut [16];
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  int         e_slot, e_pos;

  seg7_display_mux #(.REFRESH_DIV(RD), .BLANK_CYC(BC), .DP_HOLD(DH)) dut (
    .clk(clk), .rst(rst), .upd(upd), .d2(d2), .d1(d1), .d0(d0),
    .beat(beat), .an(an), .seg(seg), .dp(dp)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got an=%b seg=%b dp=%b, need an=%b seg=%b dp=%b at %0t",
               name, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0], $time);
    end
  endtask

  task automatic reset_model();
    k_m = 0; m_h = 4'd0; m_t = 4'd0; m_o = 4'd0;
    have_beat = 1'b0; lb = 0;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    e_slot = -1; e_pos = -1;
  endtask

  // Behavioural model: position in the frame comes from plain edge arithmetic.
  initial begin
    int slot, pos;
    logic [3:0] na;
    logic [6:0] ns;
    logic nd;
    lut[0] = 7'b1000000; lut[1] = 7'b1111001; lut[2] = 7'b0100100; lut[3] = 7'b0110000;
    lut[4] = 7'b0011001; lut[5] = 7'b0010010; lut[6] = 7'b0000010; lut[7] = 7'b1111000;
    lut[8] = 7'b0000000; lut[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) lut[i] = 7'b0111111;
    reset_model();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        reset_model();
      end else begin
        slot = (k_m / RD) % 4;
        pos  = k_m % RD;
        na = 4'hF; ns = 7'h7F; nd = 1'b1;
        if (pos >= BC) begin
          if (slot == 0) begin
            na = 4'b1110; ns = lut[m_o];
          end else if (slot == 1) begin
            if (m_h != 4'd0 || m_t != 4'd0) begin na = 4'b1101; ns = lut[m_t]; end
          end else if (slot == 2) begin
            if (m_h != 4'd0) begin na = 4'b1011; ns = lut[m_h]; end
          end else begin
`ifdef HEARTBEAT_DP_EN
            if (have_beat && (k_m - lb) <= DH) begin na = 4'b0111; nd = 1'b0; end
`endif
          end
        end
        e_an = na; e_seg = ns; e_dp = nd; e_slot = slot; e_pos = pos;
        if (upd) begin m_h = d2; m_t = d1; m_o = d0; end
        if (beat) begin have_beat = 1'b1; lb = k_m; end
        k_m++;
      end
    end
  end

  // Cycle-by-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("frame", {an, seg, dp}, {e_an, e_seg, e_dp});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_upd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    tick();
    d2 = a; d1 = b; d0 = c; upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask

  // Wait (bounded) for the output reflecting a given slot/offset, then check a literal.
  task automatic lit(input string name, input int slot, input int pos,
                     input logic [3:0] xa, input logic [6:0] xs);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(e_slot == slot && e_pos == pos) && n < 80);
    if (e_slot == slot && e_pos == pos) begin
      #1;
      chk(name, {an, seg, dp}, {xa, xs, 1'b1});
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: position slot=%0d pos=%0d not reached within 80 cycles", name, slot, pos);
    end
  endtask

  initial begin
    int n;
    // 1. Reset and first slot
    tick(); tick(); tick();
    #1;
    chk("reset_outputs", {an, seg, dp}, 12'hFFF);
    rst = 1'b1;
    lit("first_blank", 0, 0, 4'b1111, 7'b1111111);
    lit("first_blank1", 0, 1, 4'b1111, 7'b1111111);
    lit("first_on", 0, 2, 4'b1110, 7'b1000000);
    lit("tens_zero_off", 1, 3, 4'b1111, 7'b1111111);
    lit("hund_zero_off", 2, 4, 4'b1111, 7'b1111111);

    // 2. Leading-zero suppression
    do_upd(4'd0, 4'd7, 4'd2);
    lit("sup_ones", 0, 3, 4'b1110, 7'b0100100);
    lit("sup_tens", 1, 4, 4'b1101, 7'b1111000);
    lit("sup_hund", 2, 5, 4'b1111, 7'b1111111);

    // 3. Inner zero and invalid code
    do_upd(4'd1, 4'd0, 4'd0);
    lit("inner_zero", 1, 2, 4'b1101, 7'b1000000);
    lit("hund_one", 2, 3, 4'b1011, 7'b1111001);
    do_upd(4'd0, 4'hC, 4'd5);
    lit("dash_tens", 1, 6, 4'b1101, 7'b0111111);
    lit("ones_five", 0, 4, 4'b1110, 7'b0010010);

    // 4. Capture gating
    do_upd(4'd0, 4'd7, 4'd2);
    d2 = 4'd9; d1 = 4'd9; d0 = 4'd9;
    repeat (64) tick();
    lit("gate_tens", 1, 3, 4'b1101, 7'b1111000);
    lit("gate_hund", 2, 3, 4'b1111, 7'b1111111);
    do_upd(4'd9, 4'd9, 4'd9);
    lit("load_hund", 2, 2, 4'b1011, 7'b0010000);
    lit("load_ones", 0, 5, 4'b1110, 7'b0010000);

    // 5. Async reset at cnt=4 of DIG1
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((k_m % (4 * RD)) != (RD + 4) && n < 80);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst", {an, seg, dp}, 12'hFFF);
    tick(); tick();
    rst = 1'b1;
    lit("rst_restart", 0, 2, 4'b1110, 7'b1000000);
    lit("rst_tens_off", 1, 2, 4'b1111, 7'b1111111);

    // 6. Heartbeat pulses then randomized traffic
    tick(); beat = 1'b1; tick(); beat = 1'b0;
    repeat (9) tick();
    beat = 1'b1; tick(); beat = 1'b0;
    repeat (40) tick();
    for (int i = 0; i < 3000; i++) begin
      tick();
      upd  = ($urandom_range(0, 15) == 0);
      d2   = 4'($urandom_range(0, 15));
      d1   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      d0   = 4'($urandom_range(0, 15));
      beat = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #1;
        rst = 1'b0;
        #1;
        chk("rand_async_rst", {an, seg, dp}, 12'hFFF);
        tick();
        rst = 1'b1;
      end
    end
    tick();
    upd = 1'b0; beat = 1'b0;
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
